// File: rtl/lector_teclado.sv
// 4x4 active-low keypad scanner: 2-flop row synchroniser, single-key debounce,
// and one registered strobe per physical press, gated by habilitar.
module lector_teclado #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       habilitar,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic       digito_stb,
    output logic [3:0] digito,
    output logic       tecla_activa
);

    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_RELEASE
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    filas_m, filas_s;
    logic [1:0]    col, col_nx;
    logic [1:0]    fila, fila_nx;
    logic [DW-1:0] dwell, dwell_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          one_low;
    logic [1:0]    fila_dec;
    logic [3:0]    patron;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Synchroniser resets to the idle (all rows high) pattern so reset never looks like a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filas_m <= 4'hF;
            filas_s <= 4'hF;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            filas_m <= filas;
            filas_s <= filas_m;
        end
    end

    // Exactly one low row is a valid single key; zero or several are ignored.
    always_comb begin
        one_low  = 1'b1;
        fila_dec = 2'd0;
        case (filas_s)
            4'b1110: fila_dec = 2'd0;
            4'b1101: fila_dec = 2'd1;
            4'b1011: fila_dec = 2'd2;
            4'b0111: fila_dec = 2'd3;
            default: one_low  = 1'b0;
        endcase
    end

    assign patron = ~(4'b0001 << fila);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_SCAN;
            col   <= 2'd0;
            fila  <= 2'd0;
            dwell <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            col   <= col_nx;
            fila  <= fila_nx;
            dwell <= dwell_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx = state;
        col_nx   = col;
        fila_nx  = fila;
        dwell_nx = dwell;
        cnt_nx   = cnt;
        case (state)
            ST_SCAN: begin
                if (dwell == DW'(SCAN_DIV - 1)) begin
                    dwell_nx = '0;
                    if (one_low) begin
                        fila_nx  = fila_dec;
                        cnt_nx   = '0;
                        state_nx = ST_DEBOUNCE;
                    end else begin
                        col_nx = col + 2'd1;
                    end
                end else begin
                    dwell_nx = dwell + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (filas_s == patron) begin
                    if (cnt == CW'(DEBOUNCE - 1)) state_nx = ST_EMIT;
                    else                           cnt_nx   = cnt + 1'b1;
                end else begin
                    dwell_nx = '0;
                    state_nx = ST_SCAN;
                end
            end
            ST_EMIT: begin
                cnt_nx   = '0;
                state_nx = ST_RELEASE;
            end
            default: begin
                // Column stays frozen, so other keys stay invisible until every row is idle.
                if (filas_s == 4'hF) begin
                    if (cnt == CW'(DEBOUNCE - 1)) begin
                        cnt_nx   = '0;
                        dwell_nx = '0;
                        col_nx   = col + 2'd1;
                        state_nx = ST_SCAN;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else begin
                    cnt_nx = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digito_stb <= 1'b0;
            digito     <= 4'hF;
        end else begin
            digito_stb <= (state == ST_EMIT) && habilitar;
            digito     <= ((state == ST_EMIT) && habilitar) ? key_code(fila, col) : 4'hF;
        end
    end

    assign columnas     = ~(4'b0001 << col);
    assign tecla_activa = (state != ST_SCAN);

endmodule
